// File: rtl/yin_pkg.sv
`timescale 1ns / 1ps
// Shared types and width helpers for the YIN pitch engine.
//   yin_state_e : control state (idle, accumulate, threshold search, descent)
//   dw/sum_w/prod_w : datapath widths for d(tau), its running sum and the
//                     cross-multiplied threshold comparison
//   buf_depth   : samples held per ping-pong buffer
package yin_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StSearch, StDescend} yin_state_e;

  // Width of d(tau): WINDOW squared differences of WIDTH-bit samples.
  function automatic int unsigned dw(input int unsigned width, input int unsigned window);
    return 2 * width + $clog2(window);
  endfunction

  // Width of the cumulative sum of d over all lags.
  function automatic int unsigned sum_w(input int unsigned width, input int unsigned window,
                                        input int unsigned taumax);
    return dw(width, window) + $clog2(taumax);
  endfunction

  // Covers both d*tau*2^F and thr*S.
  function automatic int unsigned prod_w(input int unsigned width, input int unsigned window,
                                         input int unsigned taumax, input int unsigned thr_frac);
    return sum_w(width, window, taumax) + thr_frac + 1;
  endfunction

  function automatic int unsigned buf_depth(input int unsigned window,
                                            input int unsigned taumax);
    return window + taumax;
  endfunction

endpackage

// File: rtl/yin_sample_bank.sv
`timescale 1ns / 1ps
// Ping-pong sample storage. One write port into buffer wr_sel_i; LANES+1 read
// ports into buffer rd_sel_i, registered (1-cycle latency).
//   clk_i           : clock
//   wr_en_i/wr_sel_i/wr_addr_i/wr_data_i : sample write
//   rd_sel_i        : buffer being analysed
//   rd_addr_i       : address of x[j]        -> rd_data_o
//   rd_lag_addr_i   : addresses of x[j+tau]  -> rd_lag_data_o (one per lane)
module yin_sample_bank #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 1536,
  parameter int unsigned Lanes = 4,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic                        wr_sel_i,
  input  logic [Aw-1:0]               wr_addr_i,
  input  logic [Width-1:0]            wr_data_i,
  input  logic                        rd_sel_i,
  input  logic [Aw-1:0]               rd_addr_i,
  input  logic [Lanes-1:0][Aw-1:0]    rd_lag_addr_i,
  output logic [Width-1:0]            rd_data_o,
  output logic [Lanes-1:0][Width-1:0] rd_lag_data_o
);

  logic [Width-1:0]            mem_q [2][Depth];
  logic [Width-1:0]            rd_data_q;
  logic [Lanes-1:0][Width-1:0] rd_lag_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_sel_i][wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_sel_i][rd_addr_i];
    for (int l = 0; l < Lanes; l++) begin
      rd_lag_data_q[l] <= mem_q[rd_sel_i][rd_lag_addr_i[l]];
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_lag_data_o = rd_lag_data_q;

endmodule

// File: rtl/yin_pitch_engine.sv
`timescale 1ns / 1ps
// Streaming YIN pitch detector. Frames of WINDOW+TAUMAX samples fill one
// buffer while the other is analysed: d(tau) for LANES lags at a time, then a
// serial cumulative-mean-normalised threshold search with descent to the local
// minimum, falling back to the global minimum when no dip is found.
//   clk_in/rst_n_in : clock, async active-low reset
//   sample_in/valid_in : audio stream (never stalled)
//   threshold_in    : Q1.THR_FRAC threshold, latched when a frame starts
//   valid_out/tau_out/voiced_out : one-cycle result pulse, held result
//   busy_out        : analysis in progress
//   overrun_out     : pulse when a completed frame is dropped
module yin_pitch_engine
  import yin_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned WINDOW   = 1024,
  parameter int unsigned TAUMAX   = 512,
  parameter int unsigned TAUMIN   = 2,
  parameter int unsigned LANES    = 4,
  parameter int unsigned THR_FRAC = 10
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [WIDTH-1:0]          sample_in,
  input  logic                      valid_in,
  input  logic [THR_FRAC:0]         threshold_in,
  output logic                      valid_out,
  output logic [$clog2(TAUMAX)-1:0] tau_out,
  output logic                      voiced_out,
  output logic                      busy_out,
  output logic                      overrun_out
);

  localparam int unsigned Depth  = buf_depth(WINDOW, TAUMAX);
  localparam int unsigned Aw     = $clog2(Depth);
  localparam int unsigned Dw     = dw(WIDTH, WINDOW);
  localparam int unsigned SumW   = sum_w(WIDTH, WINDOW, TAUMAX);
  localparam int unsigned ProdW  = prod_w(WIDTH, WINDOW, TAUMAX, THR_FRAC);
  localparam int unsigned Tw     = $clog2(TAUMAX);
  localparam int unsigned Jw     = $clog2(WINDOW);
  localparam int unsigned Groups = TAUMAX / LANES;
  localparam int unsigned Gw     = (Groups > 1) ? $clog2(Groups) : 1;
  localparam int unsigned Lw     = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [Aw-1:0] PtrLast = Aw'(Depth - 1);
  localparam logic [Jw-1:0] JLast   = Jw'(WINDOW - 1);
  localparam logic [Gw-1:0] GLast   = Gw'(Groups - 1);
  localparam logic [Lw-1:0] LLast   = Lw'(LANES - 1);
  localparam logic [Tw-1:0] TauLast = Tw'(TAUMAX - 1);
  localparam logic [Tw-1:0] TauMinL = Tw'(TAUMIN);

  yin_state_e state_q;
  logic       fin;

  // ---------------- Fill side ----------------
  logic [Aw-1:0] ptr_q;
  logic          fill_sel_q;
  logic          frame_done, start;

  assign frame_done = valid_in && (ptr_q == PtrLast);
  assign start      = frame_done && (state_q == StIdle);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q      <= '0;
      fill_sel_q <= 1'b0;
    end else if (valid_in) begin
      ptr_q <= frame_done ? '0 : ptr_q + 1'b1;
      if (start) fill_sel_q <= ~fill_sel_q;
    end
  end

  // ---------------- Read issue: one j per cycle per group ----------------
  logic          iss_run_q;
  logic [Jw-1:0] j_q;
  logic [Gw-1:0] g_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      iss_run_q <= 1'b0;
      j_q       <= '0;
      g_q       <= '0;
    end else if (fin) begin
      iss_run_q <= 1'b0;
    end else if (start) begin
      iss_run_q <= 1'b1;
      j_q       <= '0;
      g_q       <= '0;
    end else if (iss_run_q) begin
      j_q <= (j_q == JLast) ? '0 : j_q + 1'b1;
      if (j_q == JLast) begin
        g_q <= g_q + 1'b1;
        if (g_q == GLast) iss_run_q <= 1'b0;
      end
    end
  end

  logic [Aw-1:0]             rd_addr, tau_base;
  logic [LANES-1:0][Aw-1:0]  lag_addr;
  logic [WIDTH-1:0]          x_rd;
  logic [LANES-1:0][WIDTH-1:0] y_rd;

  always_comb begin
    rd_addr  = Aw'(j_q);
    tau_base = Aw'(g_q) * Aw'(LANES);
    for (int l = 0; l < LANES; l++) lag_addr[l] = rd_addr + tau_base + Aw'(l);
  end

  yin_sample_bank #(
    .Width (WIDTH),
    .Depth (Depth),
    .Lanes (LANES),
    .Aw    (Aw)
  ) u_bank (
    .clk_i         (clk_in),
    .wr_en_i       (valid_in),
    .wr_sel_i      (fill_sel_q),
    .wr_addr_i     (ptr_q),
    .wr_data_i     (sample_in),
    .rd_sel_i      (~fill_sel_q),
    .rd_addr_i     (rd_addr),
    .rd_lag_addr_i (lag_addr),
    .rd_data_o     (x_rd),
    .rd_lag_data_o (y_rd)
  );

  // ---------------- read -> absdiff -> square -> add ----------------
  logic                 s1_v_q, s1_first_q, s1_last_q, s2_v_q, s2_first_q, s2_last_q;
  logic                 s3_v_q, s3_first_q, s3_last_q;
  logic [Gw-1:0]        s1_grp_q, s2_grp_q, s3_grp_q;
  logic [WIDTH-1:0]     ad_d [LANES];
  logic [WIDTH-1:0]     ad_q [LANES];
  logic [2*WIDTH-1:0]   sq_q [LANES];
  logic [Dw-1:0]        acc_sum [LANES];
  logic [Dw-1:0]        acc_q [LANES];
  logic [Dw-1:0]        res_q [LANES];
  logic                 res_load;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      ad_d[l]    = (x_rd >= y_rd[l]) ? x_rd - y_rd[l] : y_rd[l] - x_rd;
      // The first product of a group restarts the sum, so results and
      // accumulation never stall between groups.
      acc_sum[l] = (s3_first_q ? '0 : acc_q[l]) + Dw'(sq_q[l]);
    end
  end

  assign res_load = s3_v_q && s3_last_q && !fin;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      {s1_v_q, s1_first_q, s1_last_q, s2_v_q, s2_first_q, s2_last_q} <= '0;
      {s3_v_q, s3_first_q, s3_last_q} <= '0;
      s1_grp_q <= '0;
      s2_grp_q <= '0;
      s3_grp_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        ad_q[l]  <= '0;
        sq_q[l]  <= '0;
        acc_q[l] <= '0;
        res_q[l] <= '0;
      end
    end else begin
      s1_v_q     <= iss_run_q && !fin;
      s2_v_q     <= s1_v_q && !fin;
      s3_v_q     <= s2_v_q && !fin;
      s1_first_q <= (j_q == '0);
      s1_last_q  <= (j_q == JLast);
      s1_grp_q   <= g_q;
      {s2_first_q, s2_last_q, s2_grp_q} <= {s1_first_q, s1_last_q, s1_grp_q};
      {s3_first_q, s3_last_q, s3_grp_q} <= {s2_first_q, s2_last_q, s2_grp_q};
      for (int l = 0; l < LANES; l++) begin
        ad_q[l] <= ad_d[l];
        sq_q[l] <= (2*WIDTH)'(ad_q[l]) * (2*WIDTH)'(ad_q[l]);
        if (s3_v_q)   acc_q[l] <= acc_sum[l];
        if (res_load) res_q[l] <= acc_sum[l];
      end
    end
  end

  // ---------------- Serial search / descent ----------------
  // Assumes WINDOW > LANES + 4 so a group's results are fully scanned before
  // the next group overwrites them.
  logic              scan_act_q;
  logic [Lw-1:0]     lane_q;
  logic [Gw-1:0]     scan_grp_q;
  logic [SumW-1:0]   s_sum_q, sum_new;
  logic [Dw-1:0]     fb_d_q, best_d_q, d_cur;
  logic [Tw-1:0]     fb_tau_q, best_tau_q, tau, fb_tau_n, fin_tau;
  logic [THR_FRAC:0] thr_q;
  logic [ProdW-1:0]  lhs, rhs;
  logic              is_last, tau_ok, below, fb_upd, fin_voiced;
  logic              valid_q, voiced_q, overrun_q;
  logic [Tw-1:0]     tau_q;

  always_comb begin
    tau      = Tw'(scan_grp_q) * Tw'(LANES) + Tw'(lane_q);
    d_cur    = res_q[lane_q];
    sum_new  = s_sum_q + SumW'(d_cur);
    // d'(tau) < thr  <=>  d * tau * 2^F < thr * S, with S including d(tau).
    lhs      = (ProdW'(d_cur) * ProdW'(tau)) << THR_FRAC;
    rhs      = ProdW'(thr_q) * ProdW'(sum_new);
    is_last  = (tau == TauLast);
    tau_ok   = (tau >= TauMinL);
    below    = tau_ok && (sum_new != '0) && (lhs < rhs);
    fb_upd   = tau_ok && (d_cur < fb_d_q);
    fb_tau_n = fb_upd ? tau : fb_tau_q;
    fin        = 1'b0;
    fin_tau    = best_tau_q;
    fin_voiced = 1'b1;
    if (scan_act_q) begin
      unique case (state_q)
        StSearch: begin
          if (is_last) begin
            fin        = 1'b1;
            fin_tau    = below ? tau : fb_tau_n;
            fin_voiced = below;
          end
        end
        StDescend: begin
          if (d_cur > best_d_q) begin
            fin = 1'b1;
          end else if (is_last) begin
            fin     = 1'b1;
            fin_tau = tau;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      scan_act_q <= 1'b0;
      lane_q     <= '0;
      scan_grp_q <= '0;
      s_sum_q    <= '0;
      fb_d_q     <= '1;
      fb_tau_q   <= '0;
      best_d_q   <= '0;
      best_tau_q <= '0;
      thr_q      <= '0;
      valid_q    <= 1'b0;
      tau_q      <= '0;
      voiced_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q   <= fin;
      overrun_q <= frame_done && (state_q != StIdle);
      if (fin) begin
        tau_q    <= fin_tau;
        voiced_q <= fin_voiced;
      end

      if (fin) begin
        scan_act_q <= 1'b0;
      end else if (res_load) begin
        scan_act_q <= 1'b1;
        lane_q     <= '0;
        scan_grp_q <= s3_grp_q;
      end else if (scan_act_q) begin
        lane_q <= lane_q + 1'b1;
        if (lane_q == LLast) scan_act_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StAccum;
            thr_q    <= threshold_in;
            s_sum_q  <= '0;
            fb_d_q   <= '1;
            fb_tau_q <= '0;
          end
        end
        StAccum: if (res_load) state_q <= StSearch;
        StSearch: begin
          if (scan_act_q && !fin) begin
            s_sum_q <= sum_new;
            if (fb_upd) begin
              fb_d_q   <= d_cur;
              fb_tau_q <= tau;
            end
            if (below) begin
              state_q    <= StDescend;
              best_tau_q <= tau;
              best_d_q   <= d_cur;
            end
          end
        end
        StDescend: begin
          if (scan_act_q && !fin) begin
            best_tau_q <= tau;
            best_d_q   <= d_cur;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Stay busy during the result pulse so a frame completing then is dropped.
      if (valid_q) state_q <= StIdle;
    end
  end

  assign valid_out   = valid_q;
  assign tau_out     = tau_q;
  assign voiced_out  = voiced_q;
  assign overrun_out = overrun_q;
  assign busy_out    = (state_q != StIdle);

endmodule

// File: doc/yin_pitch_engine.md
Name: yin_pitch_engine

Overview:
- Parametrised streaming YIN pitch detector; successor to the fixed 4-lane, 2048-window detector.
- Captures frames of WINDOW+TAUMAX samples into ping-pong buffers and computes difference function d(tau) with LANES parallel lags.
- Serially applies cumulative-mean-normalised threshold search (cross-multiplied, no divider) with runtime threshold, TAUMIN floor, early termination and voiced/unvoiced flag.
- Sits between the audio sample stream and the pitch-shift control logic.

Parameters:
- WIDTH, 16, unsigned sample width
- WINDOW, 1024, integration length in samples
- TAUMAX, 512, lags 0..TAUMAX-1 evaluated; TAUMAX % LANES == 0
- TAUMIN, 2, smallest lag eligible as result (>=1)
- LANES, 4, lags accumulated in parallel (power of 2)
- THR_FRAC, 10, fraction bits of threshold_in

Ports:
- clk_in, in, 1, clock
- rst_n_in, in, 1, asynchronous active-low reset
- sample_in, in, WIDTH, audio sample
- valid_in, in, 1, sample_in valid this cycle
- threshold_in, in, THR_FRAC+1, unsigned Q1.THR_FRAC threshold; latched at compute start
- valid_out, out, 1, one-cycle result pulse
- tau_out, out, clog2(TAUMAX), detected lag
- voiced_out, out, 1, 1 = threshold dip found; 0 = fallback minimum
- busy_out, out, 1, compute in progress
- overrun_out, out, 1, one-cycle pulse: completed frame discarded

Behaviour:
- Reset (async assert, sync-release use): all outputs 0, fill pointer 0, FSM IDLE, both buffers empty; in-flight compute abandoned, no valid_out.
- Fill: each valid_in writes fill buffer at ptr, ptr++. At ptr == WINDOW+TAUMAX-1 write: if FSM IDLE, buffers swap, threshold latched, FSM -> ACCUM next cycle; else frame discarded, overrun_out pulses, ptr -> 0, same buffer refilled. Filling never stalls.
- DW = 2*WIDTH+clog2(WINDOW). d(tau) = sum over j=0..WINDOW-1 of (x[j]-x[j+tau])^2, unsigned abs-diff, no saturation needed.
- ACCUM: group g covers tau = g*LANES+l. One j per cycle; pipeline read -> absdiff -> square -> add (4 stages). Group result registered 4 cycles after last read; next group reads start immediately (accumulators double-buffered).
- SEARCH (serial, one tau per cycle over the completed group, overlapped with next group's ACCUM): S += d(tau) (width DW+clog2(TAUMAX)).
  - Below-threshold test: tau >= TAUMIN, S != 0, and d*tau*2^THR_FRAC < thr*S. tau 0 never eligible.
  - Fallback tracking: minimum raw d over tau >= TAUMIN; ties keep the lower tau.
  - First below-threshold tau -> DESCEND with best = tau.
- DESCEND: while d(tau+1) <= d(best) (raw d), best = tau+1. Stop at first strict increase or at tau = TAUMAX-1. On stop: tau_out = best, voiced_out = 1, valid_out pulses, remaining groups aborted, FSM -> IDLE.
- No dip after tau = TAUMAX-1: tau_out = fallback tau, voiced_out = 0, valid_out pulses, FSM -> IDLE.
- Descent crossing a group boundary waits for the next group's results.
- tau_out and voiced_out hold until the next valid_out.
- busy_out = (FSM != IDLE).
- Frame completing the same cycle valid_out pulses: FSM is not IDLE, so the frame is discarded (overrun).
- Worst-case latency from frame complete to valid_out: (TAUMAX/LANES)*WINDOW + LANES + 8 cycles.

Decomposition:
- yin_pkg: state enum (IDLE, ACCUM, SEARCH, DESCEND), DW/SUM_W/PROD_W width functions, buffer-depth constant.
- Sub-module yin_sample_bank: ping-pong sample storage, one write port broadcast to LANES+1 replicated read ports (x[j], x[j+tau0..tau0+LANES-1]), 1-cycle read latency.

Test Plan:
- Params WINDOW=256, TAUMAX=128, TAUMIN=2, LANES=4, threshold 0.1 (102). Sawtooth period 40, amplitude 0..39*256 -> valid_out, tau_out=40, voiced_out=1, before full search completes.
- All-zero frame -> S=0 throughout -> voiced_out=0, tau_out=2 (tie, lowest eligible).
- threshold_in=0, white-noise frame -> voiced_out=0, tau_out = bench-model argmin raw d, valid_out within bound.
- Back-to-back frames with valid_in every cycle -> first frame processed, next completed frame discarded, overrun_out single pulse, busy_out=1 throughout.
- rst_n_in low mid-ACCUM -> outputs 0 immediately, no valid_out; next full frame (period 40) -> tau_out=40.
- Period 3 with TAUMIN=4 -> tau 3 ineligible; dip found at 6 -> tau_out=6, voiced_out=1.
